// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the ALU with iterative multiply/divide.
package alu_pkg;

  localparam int unsigned ALU_AND   = 0;
  localparam int unsigned ALU_OR    = 1;
  localparam int unsigned ALU_ADD   = 2;
  localparam int unsigned ALU_XOR   = 3;
  localparam int unsigned ALU_SUB   = 6;
  localparam int unsigned ALU_SLT   = 7;
  localparam int unsigned ALU_MULT  = 8;
  localparam int unsigned ALU_MULTU = 9;
  localparam int unsigned ALU_DIV   = 10;
  localparam int unsigned ALU_DIVU  = 11;
  localparam int unsigned ALU_NOR   = 12;
  localparam int unsigned ALU_MFHI  = 13;
  localparam int unsigned ALU_MFLO  = 14;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX} state_e;

  // Low two bits of the MULT..DIVU opcodes map directly onto this enum.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_e;

  function automatic logic is_muldiv(input int unsigned code);
    return code inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative radix-2 multiply / restoring divide engine producing HI/LO.
//   state   | meaning
//   ST_IDLE | waiting for start, HI/LO hold last result
//   ST_ITER | one multiply/divide bit per cycle, WIDTH cycles
//   ST_FIX  | apply signs (or divide-by-zero result) and write HI/LO
module muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_e       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     divisor;
  logic                 is_div, neg_q, neg_r, dbz;
  logic                 signed_op, div_op, b_zero, last_iter;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum, trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign div_op    = (op == MD_DIV) || (op == MD_DIVU);
  assign b_zero    = (b == '0);
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  // acc = {upper, lower}: product accumulator for multiply, {remainder, quotient} for divide.
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & divisor};
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, divisor};
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (div_op && b_zero) ? ST_FIX : ST_ITER;
      ST_ITER: if (last_iter) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      acc         <= '0;
      divisor     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == ST_FIX);
      case (state)
        ST_IDLE: if (start) begin
          count   <= '0;
          is_div  <= div_op;
          dbz     <= div_op && b_zero;
          divisor <= mag_b;
          neg_q   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r   <= signed_op && a[WIDTH-1];
          // On divide-by-zero the raw dividend is kept so HI can return it unmodified.
          acc     <= {{WIDTH{1'b0}}, (div_op && b_zero) ? a : mag_a};
        end
        ST_ITER: begin
          count <= count + CNT_W'(1);
          if (is_div)
            acc <= trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {add_sum, acc[WIDTH-1:1]};
        end
        ST_FIX: begin
          div_by_zero <= dbz;
          if (dbz) begin
            hi <= acc[WIDTH-1:0];
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: zero-latency combinational ops plus the iterative HI/LO multiply/divide engine.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] alu_control,
  input  logic              start,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              div_by_zero
);

  logic start_md;

  assign start_md = start && is_muldiv(32'(alu_control));

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .reset       (reset),
    .start       (start_md),
    .op          (muldiv_op_e'(alu_control[1:0])),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // MFHI/MFLO read the registers as they are, even mid-operation.
  always_comb begin
    result = '0;
    case (alu_control)
      CTRL_W'(ALU_AND):  result = a & b;
      CTRL_W'(ALU_OR):   result = a | b;
      CTRL_W'(ALU_ADD):  result = a + b;
      CTRL_W'(ALU_XOR):  result = a ^ b;
      CTRL_W'(ALU_SUB):  result = a - b;
      CTRL_W'(ALU_SLT):  result = WIDTH'($signed(a) < $signed(b));
      CTRL_W'(ALU_NOR):  result = ~(a | b);
      CTRL_W'(ALU_MFHI): result = hi;
      CTRL_W'(ALU_MFLO): result = lo;
      default:           result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized and directed bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  ctrl;
  logic        start;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done, dbz;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int st_cyc = 0;
  bit chk_en = 0;

  // reference model state
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;
  logic [31:0] p_hi, p_lo;
  logic        p_dbz;

  alu_muldiv #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alu_control(ctrl), .start(start),
    .result(result), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] comb_ref(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] h,
                                           input logic [31:0] l);
    case (c)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd3:    return x ^ y;
      4'd6:    return x - y;
      4'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12:   return ~(x | y);
      4'd13:   return h;
      4'd14:   return l;
      default: return 32'd0;
    endcase
  endfunction

  // Expected HI/LO/div_by_zero and number of busy cycles for a launched operation.
  task automatic md_ref(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l, output logic z,
                        output int busy_cycles);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    z = 1'b0;
    busy_cycles = 33;
    h = '0;
    l = '0;
    if (c == 4'd8 || c == 4'd9) begin
      if (c == 4'd8) p = sx * sy;
      else           p = ux * uy;
      h = p[63:32];
      l = p[31:0];
    end else if (y == 32'd0) begin
      h = x;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
      busy_cycles = 1;
    end else if (c == 4'd10) begin
      q = sx / sy;
      r = sx % sy;
      h = r[31:0];
      l = q[31:0];
    end else begin
      p = ux / uy;
      h = 32'(ux % uy);
      l = p[31:0];
    end
  endtask

  always @(posedge clk) begin
    cyc_n++;
    m_done = 1'b0;
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_dbz  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_dbz  = p_dbz;
      end
    end else if (start && ctrl inside {4'd8, 4'd9, 4'd10, 4'd11}) begin
      md_ref(ctrl, a, b, p_hi, p_lo, p_dbz, m_left);
    end
  end

  always @(negedge clk) begin
    logic [31:0] er;
    if (chk_en) begin
      er = comb_ref(ctrl, a, b, m_hi, m_lo);
      chk("result", result, er);
      chk("zero", 32'(zero), 32'(er == 32'd0));
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_by_zero", 32'(dbz), 32'(m_dbz));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    ctrl   = c;
    a      = x;
    b      = y;
    start  = 1'b1;
    st_cyc = cyc_n;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) chk({name, " latency"}, 32'(cyc_n - st_cyc), 32'(exp_lat));
  endtask

  task automatic comb_lit(input string name, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
    ctrl = c;
    a    = x;
    b    = y;
    #1;
    chk({name, " result"}, result, exp);
    chk({name, " zero"}, 32'(zero), 32'(exp == 32'd0));
    cyc();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    ctrl  = 4'd0;
    a     = '0;
    b     = '0;
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset dbz", 32'(dbz), 32'd0);
    chk_en = 1;
    cyc();

    comb_lit("sub 75-100", 4'd6, 32'd75, 32'd100, 32'hFFFF_FFE7);
    comb_lit("sub 5-5", 4'd6, 32'd5, 32'd5, 32'd0);
    comb_lit("slt 10<20", 4'd7, 32'd10, 32'd20, 32'd1);
    comb_lit("slt -1<1", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1);
    comb_lit("nor 0,0", 4'd12, 32'd0, 32'd0, 32'hFFFF_FFFF);

    issue(4'd8, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult", 34);
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFEB);
    cyc();

    issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", 34);
    chk("multu hi", hi, 32'hFFFF_FFFE);
    chk("multu lo", lo, 32'h0000_0001);
    cyc();
    comb_lit("mfhi", 4'd13, 32'd0, 32'd0, 32'hFFFF_FFFE);

    issue(4'd10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 34);
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'hFFFF_FFFF);
    cyc();

    issue(4'd11, 32'd100, 32'd7);
    repeat (4) cyc();
    ctrl  = 4'd11;
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done("divu", 34);
    chk("divu lo", lo, 32'd14);
    chk("divu hi", hi, 32'd2);
    cyc();

    issue(4'd11, 32'd100, 32'd0);
    wait_done("divu0", 2);
    chk("divu0 lo", lo, 32'hFFFF_FFFF);
    chk("divu0 hi", hi, 32'd100);
    chk("divu0 dbz", 32'(dbz), 32'd1);
    cyc();
    issue(4'd11, 32'd9, 32'd3);
    wait_done("divu 9/3", 34);
    chk("divu 9/3 lo", lo, 32'd3);
    chk("divu 9/3 dbz", 32'(dbz), 32'd0);
    cyc();

    issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div minneg", 34);
    chk("div minneg lo", lo, 32'h8000_0000);
    chk("div minneg hi", hi, 32'd0);
    cyc();

    issue(4'd8, 32'd123, 32'd456);
    repeat (9) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort no done", 32'(pulses), 32'd0);
    cyc();
    issue(4'd9, 32'd6, 32'd7);
    wait_done("after reset", 34);
    chk("after reset lo", lo, 32'd42);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      ctrl  = 4'($urandom_range(0, 15));
      a     = pick();
      b     = pick();
      start = ($urandom_range(0, 2) == 0);
      cyc();
    end
    start = 1'b0;
    repeat (40) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
